// File: rtl/fact_accel_if.sv
// fact_accel_if: register bus between the SoC decoder and fact_accel.
interface fact_accel_if;
  logic [2:0] a;
  logic we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic irq;
  modport master(output a, we, wd, input rd, irq);
  modport slave(input a, we, wd, output rd, irq);
endinterface

// File: rtl/fact_accel.sv
// fact_accel: memory-mapped iterative factorial with overflow abort and cycle counter; FACT_ACCEL_IRQ_EN adds the completion interrupt.
module fact_accel #(
  parameter int N_W = 4,
  parameter int RES_W = 32
) (
  input logic clk,
  input logic rst,
  fact_accel_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [N_W-1:0] n_reg, i;
  logic [RES_W-1:0] acc, result;
  logic [RES_W+N_W-1:0] p;
  logic [31:0] cycles;
  logic go_mirror, done, err, busy, go, fin, ovf, last, pend;
  assign p = (RES_W+N_W)'(acc) * (RES_W+N_W)'(i);
  assign ovf = |p[RES_W+N_W-1:RES_W];
  assign last = i <= N_W'(1);
  assign busy = state == RUN;
  assign go = bus.we && bus.a == 3'd1 && bus.wd[0] && state == IDLE;
  assign fin = busy && (last || ovf);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = go ? RUN : fin ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg <= '0;
      go_mirror <= 1'b0;
      i <= '0;
      acc <= '0;
      result <= '0;
      cycles <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      if (bus.we && bus.a == 3'd0) n_reg <= bus.wd[N_W-1:0];
      if (bus.we && bus.a == 3'd1) go_mirror <= bus.wd[0];
      if (go) begin
        i <= n_reg;
        acc <= RES_W'(1);
        cycles <= '0;
        done <= 1'b0;
        err <= 1'b0;
      end else if (busy) begin
        cycles <= cycles + 32'd1;
        if (last) begin
          result <= acc;
          done <= 1'b1;
        end else if (ovf) begin
          // the product no longer fits the accumulator: abort at the first overflowing step
          result <= '0;
          err <= 1'b1;
          done <= 1'b1;
        end else begin
          acc <= p[RES_W-1:0];
          i <= i - N_W'(1);
        end
      end
    end
  end
`ifdef FACT_ACCEL_IRQ_EN
  // completion takes priority over a coincident clear so no interrupt is lost
  always_ff @(posedge clk)
    if (rst) pend <= 1'b0;
    else if (fin) pend <= 1'b1;
    else if (bus.we && bus.a == 3'd5 && bus.wd[0]) pend <= 1'b0;
  assign bus.irq = pend;
`else
  assign pend = 1'b0;
  assign bus.irq = 1'b0;
`endif
  always_comb begin
    bus.rd = '0;
    case (bus.a)
      3'd0: bus.rd = 32'(n_reg);
      3'd1: bus.rd = {30'd0, busy, go_mirror};
      3'd2: bus.rd = {29'd0, busy, err, done};
      3'd3: bus.rd = 32'(result);
      3'd4: bus.rd = cycles;
      3'd5: bus.rd = {31'd0, pend};
      default: bus.rd = '0;
    endcase
  end
endmodule

// File: tb/tb_fact_accel.sv
// tb_fact_accel: directed scoreboard bench; expected reads are queued by stimulus and checked by a negedge monitor.
module tb_fact_accel;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fact_accel_if bus();
  fact_accel dut(.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    string name;
    int addr;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  logic [31:0] act;
  bit req = 1'b0;
  int errors = 0;
  int checks = 0;
  // addr 8 selects the irq pin instead of rd
  always @(negedge clk)
    if (req) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got a read with no expected value");
      end else begin
        me = sb.pop_front();
        act = me.addr == 8 ? {31'd0, bus.irq} : bus.rd;
        if (act !== me.exp) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", me.name, act, me.exp);
        end
      end
    end
  task automatic cyc(input bit w, input int addr, input logic [31:0] data, input bit c,
                     input logic [31:0] ex, input string nm);
    bus.we = w;
    bus.a = addr[2:0];
    bus.wd = data;
    if (c) begin
      sb.push_back('{nm, addr, ex});
      req = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    req = 1'b0;
  endtask
  task automatic wr(input int addr, input logic [31:0] data);
    cyc(1'b1, addr, data, 1'b0, 32'd0, "");
  endtask
  task automatic chk(input int addr, input logic [31:0] ex, input string nm);
    cyc(1'b0, addr, 32'd0, 1'b1, ex, nm);
  endtask
  task automatic go(input int n);
    wr(0, 32'(n));
    wr(1, 32'd1);
  endtask
  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      bus.a = 3'd2;
      @(negedge clk);
      ok = !bus.rd[2];
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still 1 after 200 cycles, required 0", nm);
    end
  endtask
  initial begin
    bus.a = 3'd0;
    bus.we = 1'b0;
    bus.wd = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 8; a++) chk(a, 32'd0, "reset_rd");
    chk(8, 32'd0, "reset_irq");
    go(5);
    repeat (5) chk(2, 32'd4, "n5_busy");
    chk(2, 32'd1, "n5_status");
    chk(3, 32'd120, "n5_result");
    chk(4, 32'd5, "n5_cycles");
    go(0);
    chk(2, 32'd4, "n0_busy");
    chk(2, 32'd1, "n0_done");
    chk(3, 32'd1, "n0_result");
    chk(4, 32'd1, "n0_cycles");
    go(1);
    chk(2, 32'd4, "n1_busy");
    chk(2, 32'd1, "n1_done");
    chk(3, 32'd1, "n1_result");
    chk(4, 32'd1, "n1_cycles");
    go(12);
    wait_idle("n12");
    chk(3, 32'd479001600, "n12_result");
    chk(4, 32'd12, "n12_cycles");
    chk(2, 32'd1, "n12_status");
    go(13);
    wait_idle("n13");
    chk(2, 32'd3, "n13_status");
    chk(3, 32'd0, "n13_result");
    chk(4, 32'd12, "n13_cycles");
    go(6);
    wr(6, 32'hffff_ffff);
    wr(0, 32'd3);
    wr(1, 32'd1);
    wait_idle("n6");
    chk(3, 32'd720, "n6_result");
    chk(0, 32'd3, "n6_nreg");
    chk(1, 32'd1, "n6_ctrl");
    chk(4, 32'd6, "n6_cycles");
    wr(3, 32'd5);
    chk(3, 32'd720, "ro_ignored");
    chk(6, 32'd0, "a6_zero");
    go(7);
    wr(6, 32'd0);
    wr(6, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 8; a++) chk(a, 32'd0, "midrun_reset_rd");
    chk(8, 32'd0, "midrun_reset_irq");
    go(4);
    wait_idle("n4");
    chk(3, 32'd24, "n4_result");
    cyc(1'b1, 0, 32'd9, 1'b1, 32'd4, "wr_rd_old");
    chk(0, 32'd9, "n_new");
`ifdef FACT_ACCEL_IRQ_EN
    chk(8, 32'd1, "irq_set");
    chk(5, 32'd1, "irq_reg");
    wr(5, 32'd1);
    chk(8, 32'd0, "irq_clr");
    go(1);
    wr(5, 32'd1);
    chk(8, 32'd1, "irq_set_wins");
    wr(5, 32'd1);
    chk(8, 32'd0, "irq_clr2");
`else
    chk(8, 32'd0, "irq_off");
    chk(5, 32'd0, "irq_reg_off");
    go(1);
    wr(5, 32'd1);
    chk(8, 32'd0, "irq_off2");
`endif
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
